// File: rtl/aula_20201105_qsys_ledr_sequencer.sv
// LED pattern sequencer: a CPU-programmed stepper that pushes each new
// 8-bit pattern to the ledr PIO through its own Avalon-MM master port.
module aula_20201105_qsys_ledr_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        irq
);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t      state;
    logic        run;
    logic        mode;
    logic        irq_en;
    logic [7:0]  seed;
    logic [23:0] period;
    logic [7:0]  value;
    logic [23:0] presc;
    logic [2:0]  step;
    logic        wrap;
    logic        pending;

    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_seed;
    logic        wr_period;
    logic        wr_status;
    logic [23:0] last_count;
    logic        tick;
    logic        step_now;
    logic [7:0]  next_value;
    logic        wrap_set;
    logic        busy;
    logic        unused_bits;

    assign wr_en     = chipselect & ~write_n;
    assign wr_ctrl   = wr_en & (address == 2'd0);
    assign wr_seed   = wr_en & (address == 2'd1);
    assign wr_period = wr_en & (address == 2'd2);
    assign wr_status = wr_en & (address == 2'd3);

    // A period of 0 behaves like 1: terminal count is then 0.
    assign last_count = (period == 24'd0) ? 24'd0 : period - 24'd1;
    assign tick       = run & (presc == last_count);
    assign step_now   = tick & ~wr_seed;
    assign next_value = mode ? value + 8'd1 : {value[6:0], value[7]};
    assign wrap_set   = step_now & (mode ? (value == 8'hFF) : (step == 3'd7));
    assign busy       = (state == S_WRITE) | pending;

    assign m_address   = 2'd0;
    assign unused_bits = ^writedata[31:24];

    always_comb begin
        readdata = 32'd0;
        unique case (address)
            2'd0: readdata = {29'd0, irq_en, mode, run};
            2'd1: readdata = {24'd0, seed};
            2'd2: readdata = {8'd0, period};
            2'd3: readdata = {22'd0, wrap, busy, value};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            mode   <= 1'b0;
            irq_en <= 1'b0;
            seed   <= 8'd0;
            period <= 24'd0;
        end else begin
            if (wr_ctrl) begin
                run    <= writedata[0];
                mode   <= writedata[1];
                irq_en <= writedata[2];
            end
            if (wr_seed) seed <= writedata[7:0];
            if (wr_period) period <= writedata[23:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= 24'd0;
        end else if (wr_ctrl | wr_period | wr_seed | ~run | tick) begin
            presc <= 24'd0;
        end else begin
            presc <= presc + 24'd1;
        end
    end

    // A seed write overrides a coincident tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= 8'd0;
            step  <= 3'd0;
            wrap  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wr_seed) begin
                value <= writedata[7:0];
                step  <= 3'd0;
            end else if (tick) begin
                value <= next_value;
                if (!mode) step <= step + 3'd1;
            end
            if (wrap_set) wrap <= 1'b1;
            else if (wr_status) wrap <= 1'b0;
            irq <= irq_en & (wrap | wrap_set);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pending) begin
                        state        <= S_WRITE;
                        pending      <= 1'b0;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= {24'd0, value};
                    end
                end
                S_WRITE: begin
                    if (!m_waitrequest) begin
                        state        <= S_IDLE;
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                    end
                end
            endcase
            // New work during a write collapses into one follow-up write.
            if (wr_seed | tick) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aula_20201105_qsys_ledr_sequencer.sv
// Directed and randomized checks of the LED sequencer against a
// pattern-level model of the expected master write stream.
module tb_aula_20201105_qsys_ledr_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        irq;

    aula_20201105_qsys_ledr_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .m_address(m_address),
        .m_chipselect(m_chipselect),
        .m_write_n(m_write_n),
        .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest),
        .irq(irq)
    );

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] wq_val[$];
    int          wq_cyc[$];
    logic [31:0] ev[$];
    int          ec[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Completed master writes, tagged with the cycle index before the edge.
    always @(posedge clk) begin
        if (m_chipselect && !m_write_n && !m_waitrequest) begin
            wq_val.push_back(m_writedata);
            wq_cyc.push_back(cyc);
        end
    end

    function automatic logic [7:0] model_step(input int v, input bit m);
        int r;
        if (m) r = (v + 1) % 256;
        else r = (v * 2) % 256 + v / 128;
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic clear_q();
        wq_val.delete();
        wq_cyc.delete();
        ev.delete();
        ec.delete();
    endtask

    task automatic check_queue(input string tag, input bit exact);
        if (exact) chk({tag, " count"}, wq_val.size(), ev.size());
        else chk({tag, " enough"}, 32'(wq_val.size() >= ev.size()), 32'd1);
        for (int i = 0; i < ev.size() && i < wq_val.size(); i++) begin
            chk($sformatf("%s val[%0d]", tag, i), wq_val[i], ev[i]);
            chk($sformatf("%s cyc[%0d]", tag, i), wq_cyc[i], ec[i]);
        end
    endtask

    initial begin
        logic [31:0] d;
        int ks, e, s, p, n, v, w;
        bit m;

        reset_n = 1'b0;
        address = 2'd0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = 32'd0;
        m_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("reset rd%0d", a), d, 32'd0);
        end
        chk("reset cs", m_chipselect, 1'b0);
        chk("reset wn", m_write_n, 1'b1);
        chk("reset wd", m_writedata, 32'd0);
        chk("reset irq", irq, 1'b0);
        chk("maddr", m_address, 2'd0);

        // Seed write while stopped
        clear_q();
        bus_wr(2'd1, 32'h81);
        ks = cyc;
        repeat (4) @(negedge clk);
        ev.push_back(32'h81); ec.push_back(ks + 1);
        check_queue("seed", 1'b1);
        rd(2'd3, d);
        chk("seed status", d, 32'h081);

        // Rotate with PERIOD=4
        bus_wr(2'd2, 32'd4);
        clear_q();
        bus_wr(2'd1, 32'h01);
        ks = cyc;
        bus_wr(2'd0, 32'h1);
        e = cyc;
        ev.push_back(32'h01); ec.push_back(ks + 1);
        v = 1;
        for (int i = 1; i <= 8; i++) begin
            v = model_step(v, 1'b0);
            ev.push_back(32'(v)); ec.push_back(e + 4 * i + 1);
        end
        repeat (34) @(negedge clk);
        bus_wr(2'd0, 32'h0);
        repeat (3) @(negedge clk);
        check_queue("rotate", 1'b1);
        rd(2'd3, d);
        chk("rotate status", d, 32'h201);
        chk("rotate irq", irq, 1'b0);
        bus_wr(2'd3, 32'h0);

        // Increment with wrap and irq
        bus_wr(2'd2, 32'd2);
        clear_q();
        bus_wr(2'd1, 32'hFE);
        ks = cyc;
        bus_wr(2'd0, 32'h7);
        e = cyc;
        repeat (3) @(negedge clk);
        chk("irq before wrap", irq, 1'b0);
        @(negedge clk);
        chk("irq at wrap", irq, 1'b1);
        bus_wr(2'd0, 32'h4);
        repeat (3) @(negedge clk);
        ev.push_back(32'hFE); ec.push_back(ks + 1);
        ev.push_back(32'hFF); ec.push_back(e + 3);
        ev.push_back(32'h00); ec.push_back(e + 5);
        check_queue("incr", 1'b1);
        chk("irq held", irq, 1'b1);
        bus_wr(2'd3, 32'h0);
        chk("irq status edge", irq, 1'b1);
        @(negedge clk);
        chk("irq cleared", irq, 1'b0);
        rd(2'd3, d);
        chk("incr status", d, 32'h000);

        // Stalled master write
        bus_wr(2'd2, 32'd3);
        clear_q();
        m_waitrequest = 1'b1;
        bus_wr(2'd1, 32'h10);
        bus_wr(2'd0, 32'h3);
        e = cyc;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            rd(2'd3, d);
            chk($sformatf("stall cs%0d", i), m_chipselect, 1'b1);
            chk($sformatf("stall wn%0d", i), m_write_n, 1'b0);
            chk($sformatf("stall wd%0d", i), m_writedata, 32'h10);
            chk($sformatf("stall busy%0d", i), d[8], 1'b1);
        end
        bus_wr(2'd0, 32'h0);
        chk("stall cs end", m_chipselect, 1'b1);
        m_waitrequest = 1'b0;
        repeat (4) @(negedge clk);
        ev.push_back(32'h10); ec.push_back(e + 10);
        ev.push_back(32'h13); ec.push_back(e + 12);
        check_queue("stall", 1'b1);
        rd(2'd3, d);
        chk("stall status", d, 32'h013);

        // Seed write colliding with a tick
        bus_wr(2'd2, 32'd4);
        clear_q();
        bus_wr(2'd1, 32'h03);
        bus_wr(2'd0, 32'h1);
        e = cyc;
        repeat (3) @(negedge clk);
        bus_wr(2'd1, 32'h5A);
        bus_wr(2'd0, 32'h0);
        repeat (3) @(negedge clk);
        ev.push_back(32'h03); ec.push_back(e);
        ev.push_back(32'h5A); ec.push_back(e + 5);
        check_queue("collide", 1'b1);

        // PERIOD=0 behaves as 1: every other step reaches the PIO
        bus_wr(2'd2, 32'd0);
        clear_q();
        bus_wr(2'd1, 32'h00);
        bus_wr(2'd0, 32'h3);
        e = cyc;
        repeat (5) @(negedge clk);
        ev.push_back(32'h00); ec.push_back(e);
        ev.push_back(32'h01); ec.push_back(e + 2);
        ev.push_back(32'h03); ec.push_back(e + 4);
        check_queue("period0", 1'b0);
        bus_wr(2'd0, 32'h0);
        repeat (4) @(negedge clk);

        // Reset during a stalled write
        m_waitrequest = 1'b1;
        bus_wr(2'd1, 32'h77);
        @(negedge clk);
        chk("pre-reset cs", m_chipselect, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async cs", m_chipselect, 1'b0);
        chk("async wn", m_write_n, 1'b1);
        chk("async wd", m_writedata, 32'd0);
        chk("async irq", irq, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        m_waitrequest = 1'b0;
        clear_q();
        repeat (3) @(negedge clk);
        check_queue("post-reset", 1'b1);
        rd(2'd3, d);
        chk("post-reset status", d, 32'd0);

        // Randomized runs
        for (int it = 0; it < 6; it++) begin
            p = $urandom_range(2, 6);
            n = $urandom_range(1, 12);
            m = 1'($urandom_range(0, 1));
            s = $urandom_range(0, 255);
            bus_wr(2'd3, 32'h0);
            bus_wr(2'd2, 32'(p));
            clear_q();
            bus_wr(2'd1, 32'(s));
            ks = cyc;
            bus_wr(2'd0, {30'd0, m, 1'b1});
            e = cyc;
            ev.push_back(32'(s)); ec.push_back(ks + 1);
            v = s;
            w = 0;
            for (int j = 1; j <= n; j++) begin
                if (m && v == 255) w = 1;
                if (!m && j % 8 == 0) w = 1;
                v = model_step(v, m);
                ev.push_back(32'(v)); ec.push_back(e + j * p + 1);
            end
            repeat (n * p) @(negedge clk);
            bus_wr(2'd0, 32'h0);
            repeat (4) @(negedge clk);
            check_queue($sformatf("rand%0d", it), 1'b1);
            rd(2'd3, d);
            chk($sformatf("rand%0d status", it), d, 32'(w * 512 + v));
            chk($sformatf("rand%0d irq", it), irq, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/aula_20201105_qsys_ledr_sequencer.md
# aula_20201105_qsys_ledr_sequencer

Autonomous pattern sequencer for the 8-bit red-LED PIO. The CPU configures it through a small Avalon-MM slave (run/mode/period/seed). It then steps an 8-bit pattern at a programmable rate and pushes each new value to the LED PIO's data register through its own Avalon-MM master port. The block sits in the Qsys system between the CPU data master and the `ledr` PIO slave, and is the PIO's only writer.

## Interface
- No parameters; widths fixed: LED width 8, period width 24.
- `clk` input 1: system clock; one clock domain for the whole block.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 2: slave register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: slave write strobe, active-low.
- `writedata` input 32: slave write data.
- `readdata` output 32: slave read data; combinational from `address`; zero wait states.
- `m_address` output 2: master address to the PIO; constant 0.
- `m_chipselect` output 1: master select.
- `m_write_n` output 1: master write strobe, active-low.
- `m_writedata` output 32: `{24'b0, value}`.
- `m_waitrequest` input 1: PIO stall; tie to 0 for the plain PIO.
- `irq` output 1: level interrupt, `wrap & irq_en`.

## Operation
- Registers: unlisted bits read 0.
  - addr 0 CTRL (rw): bit0 `run`, bit1 `mode` (0 = rotate-left, 1 = increment), bit2 `irq_en`.
  - addr 1 SEED (rw): [7:0] seed.
  - addr 2 PERIOD (rw): [23:0] clocks per step; 0 is treated as 1.
  - addr 3 STATUS: read returns [7:0] `value`, bit8 `busy`, bit9 `wrap`. Any write clears `wrap`.
- Reset values: all registers, `value`, prescaler, step counter, `wrap`, `pending` = 0; FSM IDLE. Outputs: `m_chipselect`=0, `m_write_n`=1, `m_writedata`=0, `irq`=0.
- Prescaler: counts 0..PERIOD-1 while `run`=1 and generates a `tick` on the terminal count. The prescaler is held at 0 while `run`=0, and is cleared on any CTRL or PERIOD write.
- On `tick`:
  - Mode 0: `value` <= rotate-left(`value`). A 3-bit step counter increments; on 7->0, `wrap` is set.
  - Mode 1: `value` <= `value`+1 mod 256; on 0xFF->0x00, `wrap` is set.
  - In both modes, `pending` is set.
- SEED write: `value` <= writedata[7:0]. The step counter and prescaler are cleared and `pending` is set. This applies even when `run`=0.
- Simultaneous SEED write and `tick`: the SEED write wins and the tick is discarded.
- Master FSM:
  - IDLE: if `pending`, go to WRITE, clear `pending`, latch `value` into `m_writedata`.
  - WRITE: `m_chipselect`=1, `m_write_n`=0, held stable while `m_waitrequest`=1. Go to IDLE on the first cycle with `m_waitrequest`=0.
- `busy` = (state==WRITE) | `pending`.
- A tick or SEED write during WRITE only sets `pending`. Exactly one further write follows, carrying the latest `value`; intermediate values are dropped.
- Clearing `run` does not abort an in-flight write, and it leaves `value` unchanged.

## Timing
- Slave writes update registers at the clock edge where `chipselect & ~write_n`. Reads are combinational, with no latency.
- With PERIOD=N, the first `tick` occurs N cycles after the edge that writes `run`=1; subsequent ticks follow every N cycles.
- `tick` or SEED write at edge k:
  - `pending`=1 after edge k.
  - Master write asserted after edge k+1.
  - With `m_waitrequest`=0, the write is 1 cycle; the FSM returns to IDLE after edge k+2.
  - Minimum spacing between master writes is 2 cycles, so PERIOD=1 writes every other step.
- `irq` is registered from `wrap`: it asserts on the same edge `wrap` sets (when `irq_en`=1) and deasserts the edge after the STATUS write.
- Reset asserted mid-transfer: outputs return to their idle values immediately (asynchronous); no write completes.

## Test plan
- Reset, then read all addresses -> readdata=0 everywhere; `m_chipselect`=0, `m_write_n`=1, `irq`=0.
- SEED=0x81 with `run`=0 -> one master write of 0x00000081, 2 cycles later; STATUS[7:0]=0x81.
- PERIOD=4, SEED=0x01, CTRL=0x1 -> master writes 0x02, 0x04, …, 0x80, 0x01, at 4-cycle spacing. `wrap` sets on the 8th step; `irq` stays 0 because `irq_en`=0.
- PERIOD=2, SEED=0xFE, CTRL=0x7 -> writes 0xFF, then 0x00. `irq`=1 from the 0x00 step until the STATUS write, after which `irq`=0.
- `m_waitrequest` held high for 10 cycles with PERIOD=3, increment mode -> first write stable throughout. Exactly one follow-up write, carrying the latest value; `busy`=1 throughout.
- SEED write on the same edge as a tick -> the written seed is sent, not the stepped value. Reset pulsed during WRITE -> `m_chipselect` drops asynchronously.
